// File: rtl/display_cycler_if.sv
// Channel/display bundle between the activity counters, the display cycler and the
// seven-segment driver. master drives channels and manual controls; slave is the cycler.
interface display_cycler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 4
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_enable;
    logic                     hold;
    logic                     step;
    logic [DATA_W-1:0]        selected_data;
    logic [IDX_W-1:0]         sel_idx;
    logic [NUM_CH-1:0]        sel_onehot;
    logic                     adv_tick;

    modport master (
        output ch_data, ch_enable, hold, step,
        input  selected_data, sel_idx, sel_onehot, adv_tick
    );

    modport slave (
        input  ch_data, ch_enable, hold, step,
        output selected_data, sel_idx, sel_onehot, adv_tick
    );
endinterface

// File: rtl/display_cycler.sv
// Round-robin display selector with dwell timer, enable skip mask and one-hot indicator.
// Define CYCLER_MANUAL_EN to honour the hold/step controls; otherwise rotation is purely timed.
module display_cycler #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 4,
    parameter int DWELL_CYCLES = 200_000_000
) (
    input  logic             clk100MHz,
    input  logic             reset_n,
    display_cycler_if.slave  dc
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W:0]   WRAP     = (IDX_W+1)'(NUM_CH);

    logic [IDX_W-1:0]  sel_idx_reg, sel_idx_next;
    logic [NUM_CH-1:0] sel_onehot_reg, sel_onehot_next;
    logic [CNT_W-1:0]  dwell_cnt_reg, dwell_cnt_next;
    logic [DATA_W-1:0] selected_data_reg, selected_data_next;
    logic              adv_tick_reg;

    logic              hold_act;
    logic              step_act;
    logic              any_en;
    logic              cur_dis;
    logic              term;
    logic              advance;
    logic [IDX_W-1:0]  found_idx;

    logic [DATA_W-1:0] ch_word  [NUM_CH];
    logic [IDX_W:0]    cand_sum [NUM_CH];
    logic [IDX_W-1:0]  cand_idx [NUM_CH];
    logic              cand_hit [NUM_CH];

`ifdef CYCLER_MANUAL_EN
    assign hold_act = dc.hold;
    assign step_act = dc.step;
`else
    wire unused_manual = dc.hold ^ dc.step;
    assign hold_act = 1'b0;
    assign step_act = 1'b0;
`endif

    // Candidate gi is the channel at distance gi+1 above the current one, modulo NUM_CH;
    // the last candidate is the current channel itself, covering the single-enabled case.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign ch_word[gi]  = dc.ch_data[gi*DATA_W +: DATA_W];
            assign cand_sum[gi] = {1'b0, sel_idx_reg} + (IDX_W+1)'(gi + 1);
            assign cand_idx[gi] = (cand_sum[gi] >= WRAP) ? IDX_W'(cand_sum[gi] - WRAP)
                                                         : cand_sum[gi][IDX_W-1:0];
            assign cand_hit[gi] = dc.ch_enable[cand_idx[gi]];
            assign sel_onehot_next[gi] = (sel_idx_next == IDX_W'(gi));
        end
    endgenerate

    // Nearest enabled candidate wins, so scan from the farthest down to the nearest.
    always_comb begin
        found_idx = sel_idx_reg;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                found_idx = cand_idx[i];
            end
        end
    end

    // Next-state logic: sel_idx is the state, advancing only on an advance event.
    always_comb begin
        any_en             = |dc.ch_enable;
        cur_dis            = any_en & ~dc.ch_enable[sel_idx_reg];
        term               = (dwell_cnt_reg == CNT_LAST);
        advance            = any_en & (step_act | cur_dis | (term & ~hold_act));
        sel_idx_next       = sel_idx_reg;
        dwell_cnt_next     = dwell_cnt_reg + CNT_W'(1);
        selected_data_next = '0;

        if (advance) begin
            sel_idx_next   = found_idx;
            dwell_cnt_next = '0;
        end else if (hold_act) begin
            dwell_cnt_next = dwell_cnt_reg;
        end else if (term) begin
            dwell_cnt_next = '0;
        end

        if (any_en) begin
            selected_data_next = ch_word[sel_idx_reg];
        end
    end

    always_ff @(posedge clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            sel_idx_reg       <= '0;
            sel_onehot_reg    <= NUM_CH'(1);
            dwell_cnt_reg     <= '0;
            selected_data_reg <= '0;
            adv_tick_reg      <= 1'b0;
        end else begin
            sel_idx_reg       <= sel_idx_next;
            sel_onehot_reg    <= sel_onehot_next;
            dwell_cnt_reg     <= dwell_cnt_next;
            selected_data_reg <= selected_data_next;
            adv_tick_reg      <= advance;
        end
    end

    assign dc.sel_idx       = sel_idx_reg;
    assign dc.sel_onehot    = sel_onehot_reg;
    assign dc.selected_data = selected_data_reg;
    assign dc.adv_tick      = adv_tick_reg;
endmodule

// File: doc/display_cycler.md
# display_cycler

Parametrised round-robin display selector. Presents one of NUM_CH channel values on a shared display bus for a programmable dwell time, then moves to the next enabled channel. Adds a channel-enable skip mask, a one-hot channel indicator that generalises the single distance flag, an advance strobe, and optional manual hold/step control. Sits between the activity counters (step count, distance, etc.) and the seven-segment driver.

## Interface

Parameters:
- NUM_CH, 4: number of input channels, 2..16.
- DATA_W, 4: width of each channel value.
- DWELL_CYCLES, 200_000_000: clock cycles per channel, 2 s at 100 MHz; must be ≥ 2.

Ports:
- clk100MHz, input, 1: system clock; every register is updated on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- ch_data, input, NUM_CH*DATA_W: flattened channel values; channel k is bits [k*DATA_W +: DATA_W].
- ch_enable, input, NUM_CH: 1 = channel takes part in the rotation.
- hold, input, 1: level; freezes the dwell counter.
- step, input, 1: single-cycle pulse; advances to the next channel immediately.
- selected_data, output, DATA_W: registered value of the current channel.
- sel_idx, output, $clog2(NUM_CH): index of the current channel.
- sel_onehot, output, NUM_CH: one-hot form of sel_idx, registered.
- adv_tick, output, 1: one-cycle pulse in the cycle sel_idx changes.

## Operation

- Reset state: sel_idx=0, sel_onehot=1, dwell_cnt=0, selected_data=0, adv_tick=0.
- dwell_cnt counts from 0 to DWELL_CYCLES-1. Its width is $clog2(DWELL_CYCLES).
- Advance event: fires when dwell_cnt==DWELL_CYCLES-1 and hold=0, or when step=1.
- On an advance event:
  - sel_idx ← first enabled index found searching upward from sel_idx+1, wrapping modulo NUM_CH.
  - dwell_cnt ← 0.
  - adv_tick ← 1.
- Search results:
  - If the only enabled channel is the current one, sel_idx stays the same, but dwell_cnt still resets and adv_tick still pulses.
  - If ch_enable==0, sel_idx is held, no adv_tick pulses, dwell_cnt keeps running and wrapping, and selected_data is forced to 0.
- Current channel disabled: if ch_enable[sel_idx]==0 while another channel is enabled, an advance event is forced on the next edge regardless of hold.
- Priority: step > hold. step coinciding with terminal count produces one advance only.
- selected_data ← ch_data[sel_idx] every cycle, so input changes on the displayed channel propagate without waiting for an advance.
- The state machine is sel_idx itself: NUM_CH states, with transitions only on advance events.

## Timing

- selected_data latency: 1 cycle from a ch_data change. After an advance, the new channel's data appears one cycle after the sel_idx change.
- sel_idx, sel_onehot and adv_tick update together on the advance edge.
- Free-running period per channel: exactly DWELL_CYCLES cycles from advance to advance.
- hold asserted for H cycles mid-dwell extends that dwell by H cycles.
- reset_n low at any point returns all outputs to reset values immediately, without waiting for a clock edge. Operation restarts on the first edge after deassertion with dwell_cnt=0.
- step and hold are synchronous inputs; synchronising them is the caller's job.

## Configuration

- CYCLER_MANUAL_EN defined: hold and step behave as described above.
- CYCLER_MANUAL_EN undefined:
  - The hold and step ports remain but are ignored, and no logic is generated for them.
  - Rotation is purely timed, including the forced skip of a disabled current channel.

## Test plan

All scenarios use NUM_CH=4, DATA_W=4, DWELL_CYCLES=4, ch_data={4'hD,4'hC,4'hB,4'hA}, with channel 0 = A.

- Reset then free-run, ch_enable=4'hF:
  - sel_idx steps 0→1→2→3→0, every 4 cycles.
  - selected_data follows A,B,C,D, each lagging its sel_idx by 1 cycle.
  - adv_tick pulses exactly once per step.
  - sel_onehot=1,2,4,8.
- ch_enable=4'b1010:
  - From reset, sel_idx moves 0→1 on the next edge, without waiting for the dwell.
  - It then alternates 1↔3 every 4 cycles.
  - selected_data alternates B/D.
- Terminal count and step together:
  - hold=1 for 6 cycles at dwell_cnt=2 gives a 10-cycle dwell.
  - step pulsed together with terminal count advances by one channel only.
- ch_enable=0:
  - sel_idx is held and selected_data=0.
  - adv_tick stays low for 20 cycles.
  - Re-enabling 4'h4 moves sel_idx to 2 on the next edge.
- reset_n pulsed low mid-dwell at sel_idx=2:
  - Outputs go to reset values (sel_idx=0, sel_onehot=1, selected_data=0, adv_tick=0) before the next clock edge.
  - After release, the first advance comes 4 cycles later.
- Build without CYCLER_MANUAL_EN: toggling hold and step has no effect, and the period stays exactly 4 cycles.
